// File: rtl/rip_gshare_predictor_v2_if.sv
// rip_gshare_predictor_v2_if: request/prediction/update bundle of the gshare predictor
//   master: drives req, pc and resolved-branch updates; observes ready and predictions
//   slave : the predictor itself
interface rip_gshare_predictor_v2_if #(
    parameter int INDEX_WIDTH = 10,
    parameter int HISTORY_LEN = 10,
    parameter int CTR_WIDTH   = 2
);
    logic                   ready;
    logic                   req;
    logic [31:0]            pc;
    logic                   pred_valid;
    logic                   pred;
    logic [CTR_WIDTH-1:0]   pred_ctr;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic [HISTORY_LEN-1:0] pred_history;
    logic                   update;
    logic [INDEX_WIDTH-1:0] update_index;
    logic [CTR_WIDTH-1:0]   update_ctr;
    logic [HISTORY_LEN-1:0] update_history;
    logic                   actual;
    logic                   mispredict;
    modport master (
        input  ready, pred_valid, pred, pred_ctr, pred_index, pred_history,
        output req, pc, update, update_index, update_ctr, update_history, actual, mispredict
    );
    modport slave (
        output ready, pred_valid, pred, pred_ctr, pred_index, pred_history,
        input  req, pc, update, update_index, update_ctr, update_history, actual, mispredict
    );
endinterface

// File: rtl/rip_gshare_predictor_v2.sv
// rip_gshare_predictor_v2: gshare/bimodal branch predictor with self-initialising counter table
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of rip_gshare_predictor_v2_if (request, prediction, update)
module rip_gshare_predictor_v2 #(
    parameter int INDEX_WIDTH = 10,
    parameter int HISTORY_LEN = 10,
    parameter int CTR_WIDTH   = 2,
    parameter int PC_LSB      = 2,
    parameter int HASH_MODE   = 1
) (
    input logic clk,
    input logic rst,
    rip_gshare_predictor_v2_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] WNT  = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] HALF = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
    typedef enum logic {INIT, RUN} state_t;
    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] init_addr, rd_index, wr_index;
    logic [HISTORY_LEN-1:0] spec_hist, hist_next;
    logic [CTR_WIDTH-1:0]   mem [DEPTH];
    logic [CTR_WIDTH-1:0]   wr_data, rd_data, upd_ctr;
    logic                   run, we, unused_pc;
    assign unused_pc = ^bus.pc;
    always_ff @(posedge clk)
        state <= rst ? INIT : state_next;
    always_comb begin
        run        = state == RUN;
        state_next = (!run && init_addr == '1) ? RUN : state;
        bus.ready  = run;
        bus.pred   = bus.pred_ctr >= HALF;
        upd_ctr    = bus.actual ? (bus.update_ctr == '1 ? bus.update_ctr : bus.update_ctr + 1'b1)
                                : (bus.update_ctr == '0 ? bus.update_ctr : bus.update_ctr - 1'b1);
        // the init sweep owns the write port until RUN
        we         = !rst && (!run || bus.update);
        wr_index   = run ? bus.update_index : init_addr;
        wr_data    = run ? upd_ctr : WNT;
        rd_index   = bus.pc[PC_LSB +: INDEX_WIDTH] ^ (HASH_MODE != 0 ? INDEX_WIDTH'(spec_hist) : '0);
        // write-first: a same-cycle write to the read index is forwarded
        rd_data    = (we && wr_index == rd_index) ? wr_data : mem[rd_index];
        // misprediction recovery takes priority over the speculative shift
        hist_next  = HASH_MODE == 0 ? '0
                   : (run && bus.update && bus.mispredict) ? (HISTORY_LEN)'({bus.update_history, bus.actual})
                   : (run && bus.pred_valid) ? (HISTORY_LEN)'({spec_hist, bus.pred})
                   : spec_hist;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr        <= '0;
            spec_hist        <= '0;
            bus.pred_valid   <= 1'b0;
            bus.pred_ctr     <= '0;
            bus.pred_index   <= '0;
            bus.pred_history <= '0;
        end else begin
            init_addr      <= run ? init_addr : init_addr + 1'b1;
            spec_hist      <= hist_next;
            bus.pred_valid <= run && bus.req;
            if (run && bus.req) begin
                bus.pred_ctr     <= rd_data;
                bus.pred_index   <= rd_index;
                bus.pred_history <= spec_hist;
            end
        end
    end
    always_ff @(posedge clk)
        if (we) mem[wr_index] <= wr_data;
endmodule

// File: tb/tb_rip_gshare_predictor_v2.sv
// tb_rip_gshare_predictor_v2: directed self-checking bench for rip_gshare_predictor_v2
module tb_rip_gshare_predictor_v2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [3:0] h = 4'd0;
    always #5 clk = ~clk;
    rip_gshare_predictor_v2_if #(.INDEX_WIDTH(4), .HISTORY_LEN(4), .CTR_WIDTH(2)) bus ();
    rip_gshare_predictor_v2 #(
        .INDEX_WIDTH(4), .HISTORY_LEN(4), .CTR_WIDTH(2), .PC_LSB(2), .HASH_MODE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic idle_inputs();
        bus.req = 1'b0;
        bus.pc = 32'd0;
        bus.update = 1'b0;
        bus.update_index = 4'd0;
        bus.update_ctr = 2'd0;
        bus.update_history = 4'd0;
        bus.actual = 1'b0;
        bus.mispredict = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // issue one request whose final index is t under the modelled history h, check the result
    task automatic predict(input logic [3:0] t, input logic [1:0] c, input string nm);
        logic ep;
        ep = c >= 2'd2;
        bus.req = 1'b1;
        bus.pc = {26'd0, t ^ h, 2'b00};
        tick();
        bus.req = 1'b0;
        total += 5;
        if (bus.pred_valid !== 1'b1) begin bad++; $display("FAIL %s.valid got=%0b exp=1", nm, bus.pred_valid); end
        if (bus.pred_index !== t) begin bad++; $display("FAIL %s.index got=%0h exp=%0h", nm, bus.pred_index, t); end
        if (bus.pred_ctr !== c) begin bad++; $display("FAIL %s.ctr got=%0d exp=%0d", nm, bus.pred_ctr, c); end
        if (bus.pred !== ep) begin bad++; $display("FAIL %s.pred got=%0b exp=%0b", nm, bus.pred, ep); end
        if (bus.pred_history !== h) begin bad++; $display("FAIL %s.hist got=%0b exp=%0b", nm, bus.pred_history, h); end
        tick();
        h = {h[2:0], ep};
    endtask
    task automatic upd(input logic [3:0] i, input logic [1:0] c, input logic a, input logic mp, input logic [3:0] uh);
        bus.update = 1'b1;
        bus.update_index = i;
        bus.update_ctr = c;
        bus.actual = a;
        bus.mispredict = mp;
        bus.update_history = uh;
        tick();
        idle_inputs();
        if (mp) h = {uh[2:0], a};
    endtask
    // 16-cycle sweep with req/update/mispredict held active; all must be ignored
    task automatic sweep(input string nm);
        bus.req = 1'b1;
        bus.pc = 32'h14;
        bus.update = 1'b1;
        bus.update_index = 4'd5;
        bus.update_ctr = 2'd3;
        bus.actual = 1'b1;
        bus.mispredict = 1'b1;
        bus.update_history = 4'hF;
        for (int i = 0; i < 16; i++) begin
            total += 2;
            if (bus.ready !== 1'b0) begin bad++; $display("FAIL %s.ready_low[%0d] got=%0b exp=0", nm, i, bus.ready); end
            if (bus.pred_valid !== 1'b0) begin bad++; $display("FAIL %s.valid_low[%0d] got=%0b exp=0", nm, i, bus.pred_valid); end
            tick();
        end
        idle_inputs();
        total++;
        if (bus.ready !== 1'b1) begin bad++; $display("FAIL %s.ready_high got=%0b exp=1", nm, bus.ready); end
        h = 4'd0;
    endtask
    task automatic check_reset_outputs(input string nm);
        total += 6;
        if (bus.ready !== 1'b0) begin bad++; $display("FAIL %s.ready got=%0b exp=0", nm, bus.ready); end
        if (bus.pred_valid !== 1'b0) begin bad++; $display("FAIL %s.valid got=%0b exp=0", nm, bus.pred_valid); end
        if (bus.pred !== 1'b0) begin bad++; $display("FAIL %s.pred got=%0b exp=0", nm, bus.pred); end
        if (bus.pred_ctr !== 2'd0) begin bad++; $display("FAIL %s.ctr got=%0d exp=0", nm, bus.pred_ctr); end
        if (bus.pred_index !== 4'd0) begin bad++; $display("FAIL %s.index got=%0h exp=0", nm, bus.pred_index); end
        if (bus.pred_history !== 4'd0) begin bad++; $display("FAIL %s.hist got=%0b exp=0", nm, bus.pred_history); end
    endtask
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        sweep("init");
        predict(4'd5, 2'd1, "first_pred");
    endtask
    task automatic test_saturate();
        logic [1:0] cin [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        logic       act [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] cexp[7] = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 7; i++) begin
            upd(4'd5, cin[i], act[i], 1'b0, 4'd0);
            predict(4'd5, cexp[i], $sformatf("sat%0d", i));
        end
    endtask
    task automatic test_history();
        upd(4'd4, 2'd2, 1'b1, 1'b0, 4'd0);
        upd(4'd5, 2'd3, 1'b0, 1'b1, 4'b0000);
        predict(4'd5, 2'd2, "hist_a");
        predict(4'd4, 2'd3, "hist_b");
        predict(4'd6, 2'd1, "hist_c");
    endtask
    task automatic test_recover();
        bus.req = 1'b1;
        bus.pc = {26'd0, 4'd4 ^ h, 2'b00};
        tick();
        bus.req = 1'b0;
        total += 3;
        if (bus.pred_valid !== 1'b1) begin bad++; $display("FAIL recover.valid got=%0b exp=1", bus.pred_valid); end
        if (bus.pred !== 1'b1) begin bad++; $display("FAIL recover.pred got=%0b exp=1", bus.pred); end
        if (bus.pred_index !== 4'd4) begin bad++; $display("FAIL recover.index got=%0h exp=4", bus.pred_index); end
        upd(4'd4, 2'd3, 1'b0, 1'b1, 4'b0101);
        predict(4'd6, 2'd1, "recover_hist");
    endtask
    task automatic test_forward();
        bus.req = 1'b1;
        bus.pc = {26'd0, 4'd9 ^ h, 2'b00};
        bus.update = 1'b1;
        bus.update_index = 4'd9;
        bus.update_ctr = 2'd1;
        bus.actual = 1'b1;
        tick();
        idle_inputs();
        total += 3;
        if (bus.pred_ctr !== 2'd2) begin bad++; $display("FAIL forward.ctr got=%0d exp=2", bus.pred_ctr); end
        if (bus.pred_index !== 4'd9) begin bad++; $display("FAIL forward.index got=%0h exp=9", bus.pred_index); end
        if (bus.pred_valid !== 1'b1) begin bad++; $display("FAIL forward.valid got=%0b exp=1", bus.pred_valid); end
        tick();
        h = {h[2:0], 1'b1};
        predict(4'd9, 2'd2, "forward_after");
    endtask
    task automatic test_back_to_back();
        logic [3:0] h0;
        h0 = h;
        bus.req = 1'b1;
        bus.pc = {26'd0, 4'd6 ^ h0, 2'b00};
        tick();
        total += 3;
        if (bus.pred_index !== 4'd6) begin bad++; $display("FAIL b2b_a.index got=%0h exp=6", bus.pred_index); end
        if (bus.pred_ctr !== 2'd1) begin bad++; $display("FAIL b2b_a.ctr got=%0d exp=1", bus.pred_ctr); end
        if (bus.pred_history !== h0) begin bad++; $display("FAIL b2b_a.hist got=%0b exp=%0b", bus.pred_history, h0); end
        tick();
        bus.req = 1'b0;
        total += 3;
        if (bus.pred_valid !== 1'b1) begin bad++; $display("FAIL b2b_b.valid got=%0b exp=1", bus.pred_valid); end
        if (bus.pred_index !== 4'd6) begin bad++; $display("FAIL b2b_b.index got=%0h exp=6", bus.pred_index); end
        if (bus.pred_history !== h0) begin bad++; $display("FAIL b2b_b.hist got=%0b exp=%0b", bus.pred_history, h0); end
        tick();
        h = {h0[1:0], 2'b00};
    endtask
    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        tick();
        check_reset_outputs("reset_run");
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep("resweep");
        for (int t = 0; t < 16; t++) predict(4'(t), 2'd1, $sformatf("reinit%0d", t));
    endtask
    initial begin
        test_reset();
        test_saturate();
        test_history();
        test_recover();
        test_forward();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/rip_gshare_predictor_v2.md
RIP_GSHARE_PREDICTOR_V2 -- requirements
Module: rip_gshare_predictor_v2

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 10: table address width, 2^INDEX_WIDTH entries.
REQ-002 SHALL have parameter HISTORY_LEN, default 10: global history bits, legal range 1..INDEX_WIDTH.
REQ-003 SHALL have parameter CTR_WIDTH, default 2: saturating counter width, legal range 2..4.
REQ-004 SHALL have parameter PC_LSB, default 2: lowest PC bit used for indexing.
REQ-005 SHALL have parameter HASH_MODE, default 1: 0 = bimodal, 1 = gshare.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port ready  out  1  table initialisation complete.
REQ-009 SHALL have port req  in  1  prediction request.
REQ-010 SHALL have port pc  in  32  request PC.
REQ-011 SHALL have port pred_valid  out  1  prediction outputs valid.
REQ-012 SHALL have port pred  out  1  predicted taken.
REQ-013 SHALL have port pred_ctr  out  CTR_WIDTH  counter read for this prediction.
REQ-014 SHALL have port pred_index  out  INDEX_WIDTH  table index used.
REQ-015 SHALL have port pred_history  out  HISTORY_LEN  speculative history used, as a recovery checkpoint.
REQ-016 SHALL have port update  in  1  write-back of a resolved branch.
REQ-017 SHALL have port update_index  in  INDEX_WIDTH  entry to update.
REQ-018 SHALL have port update_ctr  in  CTR_WIDTH  counter value returned at prediction.
REQ-019 SHALL have port update_history  in  HISTORY_LEN  checkpoint returned at prediction.
REQ-020 SHALL have port actual  in  1  resolved direction.
REQ-021 SHALL have port mispredict  in  1  qualifies update; triggers history recovery.

Function
REQ-022 SHALL implement a two-state FSM, INIT and RUN.
- INIT writes the weakly-not-taken value (2^(CTR_WIDTH-1)-1) to addresses 0..2^INDEX_WIDTH-1, one per cycle.
- INIT moves to RUN after the last address; the whole sweep takes exactly 2^INDEX_WIDTH cycles.
REQ-023 SHALL drive ready=1 only in RUN.
REQ-024 SHALL ignore req, update and mispredict in INIT; pred_valid stays 0.
REQ-025 SHALL compute the index as pc[PC_LSB+INDEX_WIDTH-1:PC_LSB], XORed with the zero-extended spec_hist when HASH_MODE=1; no XOR when HASH_MODE=0.
REQ-026 SHALL give one-cycle latency: req in cycle N produces pred_valid=1 in cycle N+1 only, with pred_ctr, pred_index and pred_history (spec_hist as sampled in cycle N).
REQ-027 SHALL set pred = (pred_ctr >= 2^(CTR_WIDTH-1)).
REQ-028 SHALL use a 1-read/1-write table with one-cycle read.
- A read and a write to the same index in the same cycle SHALL return the newly written value (write-first forwarding).
REQ-029 SHALL, when HASH_MODE=1 and pred_valid=1, update spec_hist on that cycle's edge to {spec_hist[HISTORY_LEN-2:0], pred}.
- A req in the same cycle SHALL use the pre-shift value.
REQ-030 SHALL, when update=1, write the counter at update_index: update_ctr+1 if actual=1, update_ctr-1 if actual=0.
- The counter SHALL saturate at 0 and at 2^CTR_WIDTH-1.
REQ-031 SHALL, when update=1 and mispredict=1 and HASH_MODE=1, set spec_hist to {update_history[HISTORY_LEN-2:0], actual}.
- This SHALL override the REQ-029 shift in the same cycle.
- When HISTORY_LEN=1, spec_hist SHALL become actual.
REQ-032 SHALL ignore mispredict when update=0.
REQ-033 SHALL hold spec_hist at 0 when HASH_MODE=0.
REQ-034 SHALL accept req and update in the same cycle with no stall and no back-pressure.

Reset
REQ-035 SHALL, on rst=1, clear the init address to 0, enter INIT, and clear spec_hist to 0.
REQ-036 SHALL, on rst=1, drive ready=0, pred_valid=0, pred=0, pred_ctr=0, pred_index=0 and pred_history=0.
REQ-037 SHALL restart the sweep at address 0 if rst is asserted mid-INIT or mid-RUN; partially written table contents are irrelevant.

Verification
(Bench parameters: INDEX_WIDTH=4, HISTORY_LEN=4, CTR_WIDTH=2, PC_LSB=2, HASH_MODE=1.)
REQ-038 Release rst -> ready=0 for 16 cycles, then 1; then req pc=0x14 -> next cycle pred_valid=1, pred_index=5, pred_ctr=1, pred=0.
REQ-039 Three updates to index 5 with actual=1 (update_ctr taken from each read) -> successive reads return 2, 3, 3 (saturated); three actual=0 updates -> 2, 1, 0, then stays 0.
REQ-040 Requests pc=0x14 with predictions 1, 1 -> spec_hist goes 0000 -> 0001 -> 0011; next req pc=0x14 -> pred_index=4'b0110, pred_history=4'b0011.
REQ-041 pred_valid=1 with pred=1 while update=1, mispredict=1, update_history=4'b0101, actual=0 -> spec_hist=4'b1010 next cycle.
REQ-042 req index 9 and update index 9 with update_ctr=1, actual=1 in the same cycle -> pred_ctr=2 next cycle.
REQ-043 rst pulsed when sweep address=7 -> ready stays 0 for a further 16 cycles after release; all entries then read 1.
